// File: rtl/kangaroo_video_timing.sv
// Single-clock, clock-enabled video timing generator.
// Produces pixel/line counts plus blanking, sync and frame strobes.
`timescale 1ns/1ps
module kangaroo_video_timing #(
  parameter int H_TOTAL      = 384,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 288,
  parameter int H_SYNC_END   = 320,
  parameter int V_TOTAL      = 264,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 248,
  parameter int V_SYNC_END   = 251
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  output logic [8:0] HCOUNT,
  output logic [8:0] VCOUNT,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC_N,
  output logic       VSYNC_N,
  output logic       LINE_START,
  output logic       VINT
);

  if (!(0 < H_ACTIVE && H_ACTIVE < H_SYNC_START &&
        H_SYNC_START < H_SYNC_END &&
        H_SYNC_END <= H_TOTAL && H_TOTAL <= 512))
  begin : g_bad_h
    $fatal(1, "kangaroo_video_timing: bad H timing");
  end

  if (!(0 < V_ACTIVE && V_ACTIVE < V_SYNC_START &&
        V_SYNC_START < V_SYNC_END &&
        V_SYNC_END <= V_TOTAL && V_TOTAL <= 512))
  begin : g_bad_v
    $fatal(1, "kangaroo_video_timing: bad V timing");
  end

  typedef enum logic [1:0] {
    H_ACTIVE_ST,
    H_FP,
    H_SYNC,
    H_BP
  } h_state_e;

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  // 10-bit so a sync end equal to a 512 total still fits
  localparam logic [9:0] H_ACT_C = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_C  = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE_C  = 10'(H_SYNC_END);
  localparam logic [9:0] V_ACT_C = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_C  = 10'(V_SYNC_START);
  localparam logic [9:0] V_SE_C  = 10'(V_SYNC_END);

  logic [8:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  h_state_e   h_state_q, h_state_d;
  logic       hblank_q, hblank_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vblank_q, vblank_d;
  logic       vsync_n_q, vsync_n_d;
  logic       line_start_q, line_start_d;
  logic       vint_q, vint_d;
  logic       h_wrap;
  logic [9:0] hn;
  logic [9:0] vn;

  always_comb begin
    h_wrap       = (hcount_q == H_LAST);
    hcount_d     = hcount_q;
    vcount_d     = vcount_q;
    h_state_d    = h_state_q;
    hblank_d     = hblank_q;
    hsync_n_d    = hsync_n_q;
    vblank_d     = vblank_q;
    vsync_n_d    = vsync_n_q;
    line_start_d = 1'b0;
    vint_d       = 1'b0;
    hn           = '0;
    vn           = '0;
    if (CE) begin
      hcount_d = h_wrap ? '0 : hcount_q + 9'd1;
      if (h_wrap) begin
        vcount_d = (vcount_q == V_LAST) ? '0
                                        : vcount_q + 9'd1;
      end
      hn = {1'b0, hcount_d};
      vn = {1'b0, vcount_d};
      // transitions keyed on the count being entered
      unique case (h_state_q)
        H_ACTIVE_ST: if (hn == H_ACT_C) h_state_d = H_FP;
        H_FP:        if (hn == H_SS_C)  h_state_d = H_SYNC;
        H_SYNC: begin
          if (hn == '0)          h_state_d = H_ACTIVE_ST;
          else if (hn == H_SE_C) h_state_d = H_BP;
        end
        H_BP:        if (hn == '0)      h_state_d = H_ACTIVE_ST;
      endcase
      hblank_d  = (h_state_d != H_ACTIVE_ST);
      hsync_n_d = (h_state_d != H_SYNC);
      if (h_wrap) begin
        vblank_d     = (vn >= V_ACT_C);
        vsync_n_d    = !(vn >= V_SS_C && vn < V_SE_C);
        line_start_d = 1'b1;
        vint_d       = (vn == V_ACT_C);
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      h_state_q    <= H_ACTIVE_ST;
      hblank_q     <= 1'b0;
      hsync_n_q    <= 1'b1;
      vblank_q     <= 1'b0;
      vsync_n_q    <= 1'b1;
      line_start_q <= 1'b0;
      vint_q       <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      h_state_q    <= h_state_d;
      hblank_q     <= hblank_d;
      hsync_n_q    <= hsync_n_d;
      vblank_q     <= vblank_d;
      vsync_n_q    <= vsync_n_d;
      line_start_q <= line_start_d;
      vint_q       <= vint_d;
    end
  end

  assign HCOUNT     = hcount_q;
  assign VCOUNT     = vcount_q;
  assign HBLANK     = hblank_q;
  assign VBLANK     = vblank_q;
  assign HSYNC_N    = hsync_n_q;
  assign VSYNC_N    = vsync_n_q;
  assign LINE_START = line_start_q;
  assign VINT       = vint_q;

endmodule

// File: tb/tb_kangaroo_video_timing.sv
// Randomized bench for kangaroo_video_timing.
// Three parameter sets checked every cycle against an arithmetic model.
`timescale 1ns/1ps
module tb_kangaroo_video_timing;

  localparam int N = 3;
  localparam int HT [N] = '{384, 24, 384};
  localparam int HA [N] = '{256, 16, 256};
  localparam int HS [N] = '{288, 18, 288};
  localparam int HE [N] = '{320, 20, 384};
  localparam int VT [N] = '{264, 12, 264};
  localparam int VA [N] = '{240, 8, 240};
  localparam int VS [N] = '{248, 9, 248};
  localparam int VE [N] = '{251, 10, 251};

  logic CLK;
  logic CLR;
  logic CE;
  logic [8:0] hc [N];
  logic [8:0] vc [N];
  logic hb [N];
  logic vb [N];
  logic hs [N];
  logic vs [N];
  logic ls [N];
  logic vi [N];

  int mh [N];
  int mv [N];
  bit mls [N];
  bit mvi [N];

  int n_chk;
  int n_fail;
  int vint_seen;
  int ls_seen;
  int cyc;

  kangaroo_video_timing u_dut (
    .CLK(CLK), .CLR(CLR), .CE(CE),
    .HCOUNT(hc[0]), .VCOUNT(vc[0]),
    .HBLANK(hb[0]), .VBLANK(vb[0]),
    .HSYNC_N(hs[0]), .VSYNC_N(vs[0]),
    .LINE_START(ls[0]), .VINT(vi[0])
  );

  kangaroo_video_timing #(
    .H_TOTAL(24), .H_ACTIVE(16),
    .H_SYNC_START(18), .H_SYNC_END(20),
    .V_TOTAL(12), .V_ACTIVE(8),
    .V_SYNC_START(9), .V_SYNC_END(10)
  ) u_small (
    .CLK(CLK), .CLR(CLR), .CE(CE),
    .HCOUNT(hc[1]), .VCOUNT(vc[1]),
    .HBLANK(hb[1]), .VBLANK(vb[1]),
    .HSYNC_N(hs[1]), .VSYNC_N(vs[1]),
    .LINE_START(ls[1]), .VINT(vi[1])
  );

  kangaroo_video_timing #(
    .H_SYNC_END(384)
  ) u_zbp (
    .CLK(CLK), .CLR(CLR), .CE(CE),
    .HCOUNT(hc[2]), .VCOUNT(vc[2]),
    .HBLANK(hb[2]), .VBLANK(vb[2]),
    .HSYNC_N(hs[2]), .VSYNC_N(vs[2]),
    .LINE_START(ls[2]), .VINT(vi[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mh[i] = 0;
      mv[i] = 0;
      mls[i] = 0;
      mvi[i] = 0;
    end
  endtask

  task automatic model_edge(input bit r, input bit c);
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      mls[i] = 0;
      mvi[i] = 0;
      if (c) begin
        mh[i] = (mh[i] + 1) % HT[i];
        if (mh[i] == 0) begin
          mv[i] = (mv[i] + 1) % VT[i];
          mls[i] = 1;
          mvi[i] = (mv[i] == VA[i]);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.hcount", i), 32'(hc[i]), mh[i]);
      chk($sformatf("u%0d.vcount", i), 32'(vc[i]), mv[i]);
      chk($sformatf("u%0d.hblank", i), 32'(hb[i]),
          32'(mh[i] >= HA[i]));
      chk($sformatf("u%0d.vblank", i), 32'(vb[i]),
          32'(mv[i] >= VA[i]));
      chk($sformatf("u%0d.hsync_n", i), 32'(hs[i]),
          32'(!(mh[i] >= HS[i] && mh[i] < HE[i])));
      chk($sformatf("u%0d.vsync_n", i), 32'(vs[i]),
          32'(!(mv[i] >= VS[i] && mv[i] < VE[i])));
      chk($sformatf("u%0d.line_start", i), 32'(ls[i]),
          32'(mls[i]));
      chk($sformatf("u%0d.vint", i), 32'(vi[i]),
          32'(mvi[i]));
    end
  endtask

  task automatic edge_chk();
    bit r;
    bit c;
    r = CLR;
    c = CE;
    @(posedge CLK);
    cyc++;
    model_edge(r, c);
    #1;
    check_all();
    if (vi[1]) vint_seen++;
    if (ls[0]) ls_seen++;
  endtask

  task automatic tick(input bit r, input bit c);
    @(negedge CLK);
    CLR = r;
    CE = c;
    edge_chk();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    CLR = 1'b1;
    CE = 1'b0;
    model_reset();

    for (int k = 0; k < 6; k++) tick(1'b1, k[0]);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("first_ce_hcount", 32'(hc[0]), 1);

    vint_seen = 0;
    ls_seen = 0;
    for (int k = 0; k < 3 * 288; k++) tick(1'b0, 1'b1);
    chk("vint_per_3_frames", vint_seen, 3);
    chk("line_starts_u0", ls_seen, 2);

    for (int k = 0; k < 1800; k++)
      tick(1'b0, $urandom_range(0, 2) == 0);

    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick(1'b0, 1'b1);
      found = (mh[1] == 19 && mv[1] == 9);
    end
    chk("reach_mid_sync", 32'(found), 1);

    @(negedge CLK);
    #1 CLR = 1'b1;
    CE = 1'b1;
    #1 model_reset();
    check_all();
    #1 CLR = 1'b0;
    #1 check_all();
    edge_chk();
    chk("restart_hcount", 32'(hc[1]), 1);
    chk("restart_vcount", 32'(vc[1]), 0);

    for (int k = 0; k < 600; k++)
      tick($urandom_range(0, 99) == 0,
           $urandom_range(0, 1) == 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kangaroo_video_timing.md
Name: kangaroo_video_timing

Overview:
Synchronous video timing controller that sequences the horizontal and vertical pixel/line counter chains, which were formerly built from cascaded dual 4-bit ripple counters. It replaces the ripple cascade with a single-clock, clock-enabled design. It decodes the counts into blanking, sync and frame-interrupt strobes. It sits between the master clock divider and the video/sprite fetch logic, and supplies HCOUNT/VCOUNT as the shared timing reference.

Parameters:
H_TOTAL, 384, pixels per line (counter wraps at H_TOTAL-1)
H_ACTIVE, 256, visible pixels per line; HBLANK starts at this count
H_SYNC_START, 288, first HCOUNT with HSYNC_N low
H_SYNC_END, 320, first HCOUNT after sync (HSYNC_N high again)
V_TOTAL, 264, lines per frame
V_ACTIVE, 240, visible lines; VBLANK starts at this line
V_SYNC_START, 248, first VCOUNT with VSYNC_N low
V_SYNC_END, 251, first VCOUNT after vertical sync

Ports:
CLK  in  1  master clock
CLR  in  1  asynchronous active-high reset (clear)
CE  in  1  pixel clock enable; all state advances only on CLK rising edges with CE=1
HCOUNT  out  9  current pixel count, 0..H_TOTAL-1
VCOUNT  out  9  current line count, 0..V_TOTAL-1
HBLANK  out  1  high while HCOUNT >= H_ACTIVE
VBLANK  out  1  high while VCOUNT >= V_ACTIVE
HSYNC_N  out  1  low while H_SYNC_START <= HCOUNT < H_SYNC_END
VSYNC_N  out  1  low while V_SYNC_START <= VCOUNT < V_SYNC_END
LINE_START  out  1  one-CLK pulse on the CE edge where HCOUNT becomes 0
VINT  out  1  one-CLK pulse on the CE edge where VCOUNT becomes V_ACTIVE with HCOUNT becoming 0

Behaviour:
- Reset: CLK is single clock. CLR is asynchronous, active-high, and overrides everything. While CLR=1: HCOUNT=0, VCOUNT=0, HBLANK=0, VBLANK=0, HSYNC_N=1, VSYNC_N=1, LINE_START=0, VINT=0, H FSM=H_ACTIVE_ST.
- Counting on CE=1:
  - HCOUNT increments by 1.
  - At HCOUNT=H_TOTAL-1, HCOUNT wraps to 0 and VCOUNT increments.
  - At VCOUNT=V_TOTAL-1 with an H wrap, VCOUNT wraps to 0.
  - No other wrap point. Counts never exceed TOTAL-1.
- CE=0: counts, FSM and level outputs hold. LINE_START and VINT are forced to 0.
- Output timing: all outputs are registered and consistent with HCOUNT/VCOUNT in the same cycle. Decodes are computed from next-count values, so there is zero latency relative to the counts.
- Horizontal FSM (advances on CE): H_ACTIVE_ST -> H_FP (count reaches H_ACTIVE) -> H_SYNC (H_SYNC_START) -> H_BP (H_SYNC_END) -> H_ACTIVE_ST (wrap to 0).
  - If H_SYNC_END==H_TOTAL, H_BP is skipped and H_SYNC goes directly to H_ACTIVE_ST on the wrap.
  - HBLANK=1 in H_FP, H_SYNC and H_BP. HSYNC_N=0 only in H_SYNC.
- Vertical decode: evaluated only on H-wrap edges. VBLANK and VSYNC_N change only together with a LINE_START edge.
- Pulse timing:
  - LINE_START=1 for exactly one CLK after the wrap edge, including frame wrap.
  - VINT=1 for exactly one CLK, once per frame, coincident with LINE_START on the first blank line.
- Elaboration checks: 0 < H_ACTIVE < H_SYNC_START < H_SYNC_END <= H_TOTAL <= 512. Same ordering applies to the V parameters. Violations are a fatal elaboration error.
- CLR asserted mid-line or mid-frame: immediate return to reset values. The first CE edge after release gives HCOUNT=1, VCOUNT=0.

Test Plan:
- Reset: assert CLR with CE toggling -> all counts 0, HSYNC_N=VSYNC_N=1, no pulses. Release, then 1 CE -> HCOUNT=1.
- Line timing: CE=1 continuously from reset -> HBLANK rises at HCOUNT=256, HSYNC_N low for HCOUNT 288..319, wrap 383->0 with VCOUNT 0->1 and a 1-cycle LINE_START.
- Frame timing: run 264*384 CE edges -> VBLANK rises at VCOUNT=240 with a single 1-cycle VINT, VSYNC_N low for lines 248..250, VCOUNT 263->0 on the final wrap. Exactly one VINT per frame over 3 frames.
- CE gating: CE=1 one cycle in three -> counts advance only on CE edges. LINE_START and VINT are each 1 CLK wide, never stretched. Period is 3x the nominal period.
- Async reset mid-operation: pulse CLR between edges at HCOUNT=300, VCOUNT=245 -> outputs clear without waiting for CLK. Restart matches the reset scenario.
- Zero back porch: H_SYNC_END=H_TOTAL=384 -> HSYNC_N rises exactly at the wrap to 0, HBLANK falls on the same edge, no H_BP state is entered.
